// File: rtl/x1_multiplier_if.sv
// X1 stage bus: X0X1 FIFO pop side in, X1X2 buffer head out.
interface x1_multiplier_if #(
    parameter int W = 64
);
    logic [5*W-1:0] RES_RX0;
    logic           SELECT_MSB_RX0;
    logic           SIGNED_RES_RX0;
    logic           X0X1_EMPTY_SX0;
    logic           X0X1_POP_SX1;
    logic           X1X2_POP_SX2;
    logic [2*W-1:0] RES_RX1;
    logic           SELECT_MSB_RX1;
    logic           SIGNED_RES_RX1;
    logic           X1X2_EMPTY_SX1;

    // Producer/consumer environment around the stage
    modport master (
        output RES_RX0, SELECT_MSB_RX0, SIGNED_RES_RX0, X0X1_EMPTY_SX0, X1X2_POP_SX2,
        input  X0X1_POP_SX1, RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1
    );

    // The X1 stage itself
    modport slave (
        input  RES_RX0, SELECT_MSB_RX0, SIGNED_RES_RX0, X0X1_EMPTY_SX0, X1X2_POP_SX2,
        output X0X1_POP_SX1, RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1
    );
endinterface

// File: rtl/x1_multiplier.sv
// X1 multiplier stage: 5:2 carry-save reduction feeding a small circular
// buffer toward X2. Only the final CPA (in X2) resolves the carries.
module x1_multiplier #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    x1_multiplier_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2*W + 2;

    logic [W-1:0]  w_v0, w_v1, w_v2, w_v3, w_v4;
    logic [W-1:0]  w_a, w_b, w_c, w_d, w_sum, w_carry;
    logic [EW-1:0] w_entry, w_head;
    logic          w_full, w_empty, w_push, w_pop;

    logic [EW-1:0] r_storage [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;

    assign w_v0 = bus.RES_RX0[0*W +: W];
    assign w_v1 = bus.RES_RX0[1*W +: W];
    assign w_v2 = bus.RES_RX0[2*W +: W];
    assign w_v3 = bus.RES_RX0[3*W +: W];
    assign w_v4 = bus.RES_RX0[4*W +: W];

    // Three chained 3:2 compressors; majority shifted left, top bit dropped
    assign w_a     = w_v0 ^ w_v1 ^ w_v2;
    assign w_b     = ((w_v0 & w_v1) | (w_v0 & w_v2) | (w_v1 & w_v2)) << 1;
    assign w_c     = w_a ^ w_b ^ w_v3;
    assign w_d     = ((w_a & w_b) | (w_a & w_v3) | (w_b & w_v3)) << 1;
    assign w_sum   = w_c ^ w_d ^ w_v4;
    assign w_carry = ((w_c & w_d) | (w_c & w_v4) | (w_d & w_v4)) << 1;

    assign w_entry = {bus.SELECT_MSB_RX0, bus.SIGNED_RES_RX0, w_carry, w_sum};

    // Flow control from registered count only: a full buffer never bypasses
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = !bus.X0X1_EMPTY_SX0 && !w_full;
    assign w_pop   = bus.X1X2_POP_SX2 && !w_empty;

    assign bus.X0X1_POP_SX1 = w_push;

    // Storage write; cleared on reset so the head reads zero immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_storage[i] <= '0;
        end else if (w_push) begin
            r_storage[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry comes straight from storage, never from RES_RX0
    assign w_head             = r_storage[r_rd_ptr];
    assign bus.RES_RX1        = w_head[2*W-1:0];
    assign bus.SIGNED_RES_RX1 = w_head[2*W];
    assign bus.SELECT_MSB_RX1 = w_head[2*W+1];
    assign bus.X1X2_EMPTY_SX1 = w_empty;
endmodule

// File: tb/tb_x1_multiplier.sv
// Directed bench for x1_multiplier: reduction values, buffer ordering,
// back-pressure, wrap and asynchronous reset.
module tb_x1_multiplier;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    x1_multiplier_if #(.W(64)) bus ();

    x1_multiplier #(.DEPTH(2), .W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] head_sum;
    assign head_sum = bus.RES_RX1[63:0] + bus.RES_RX1[127:64];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, b, c, d, e, input logic sel, input logic sg);
        bus.RES_RX0        = {e, d, c, b, a};
        bus.SELECT_MSB_RX0 = sel;
        bus.SIGNED_RES_RX0 = sg;
    endtask

    initial begin
        bus.X0X1_EMPTY_SX0 = 1'b1;
        bus.X1X2_POP_SX2   = 1'b0;
        drive(64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Reset state
        #3;
        chk("rst_empty", 128'(bus.X1X2_EMPTY_SX1), 128'd1);
        chk("rst_res", 128'(bus.RES_RX1), 128'd0);
        chk("rst_pop", 128'(bus.X0X1_POP_SX1), 128'd0);
        #10 reset_n = 1'b1;
        tick();

        // Vectors 1..5 -> 15, flags pass through
        drive(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 1'b1, 1'b0);
        bus.X0X1_EMPTY_SX0 = 1'b0;
        #1 chk("t1_pop", 128'(bus.X0X1_POP_SX1), 128'd1);
        tick();
        bus.X0X1_EMPTY_SX0 = 1'b1;
        #1;
        chk("t1_empty", 128'(bus.X1X2_EMPTY_SX1), 128'd0);
        chk("t1_sum", 128'(head_sum), 128'd15);
        chk("t1_sel", 128'(bus.SELECT_MSB_RX1), 128'd1);
        chk("t1_sgn", 128'(bus.SIGNED_RES_RX1), 128'd0);
        bus.X1X2_POP_SX2 = 1'b1;
        tick();
        bus.X1X2_POP_SX2 = 1'b0;
        chk("t1_drain", 128'(bus.X1X2_EMPTY_SX1), 128'd1);

        // All ones wrap: 5*(2^64-1) mod 2^64
        drive('1, '1, '1, '1, '1, 1'b0, 1'b1);
        bus.X0X1_EMPTY_SX0 = 1'b0;
        tick();
        bus.X0X1_EMPTY_SX0 = 1'b1;
        chk("t2_sum", 128'(head_sum), 128'hFFFF_FFFF_FFFF_FFFB);
        chk("t2_sgn", 128'(bus.SIGNED_RES_RX1), 128'd1);
        bus.X1X2_POP_SX2 = 1'b1;
        tick();
        bus.X1X2_POP_SX2 = 1'b0;

        // Fill A(100), B(200), then C(300) is held off while full
        drive(64'd100, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1);
        bus.X0X1_EMPTY_SX0 = 1'b0;
        tick();
        drive(64'd50, 64'd50, 64'd50, 64'd50, 64'd0, 1'b0, 1'b0);
        #1 chk("t3_popB", 128'(bus.X0X1_POP_SX1), 128'd1);
        tick();
        drive(64'd60, 64'd60, 64'd60, 64'd60, 64'd60, 1'b0, 1'b1);
        #1;
        chk("t3_full_block", 128'(bus.X0X1_POP_SX1), 128'd0);
        chk("t3_headA", 128'(head_sum), 128'd100);
        chk("t3_headA_sel", 128'(bus.SELECT_MSB_RX1), 128'd1);
        bus.X1X2_POP_SX2 = 1'b1;
        #1 chk("t3_no_pass", 128'(bus.X0X1_POP_SX1), 128'd0);
        tick();
        bus.X1X2_POP_SX2 = 1'b0;
        #1;
        chk("t3_headB", 128'(head_sum), 128'd200);
        chk("t3_popC", 128'(bus.X0X1_POP_SX1), 128'd1);
        tick();
        bus.X0X1_EMPTY_SX0 = 1'b1;
        chk("t3_headB_hold", 128'(head_sum), 128'd200);
        bus.X1X2_POP_SX2 = 1'b1;
        tick();
        chk("t3_headC", 128'(head_sum), 128'd300);
        chk("t3_headC_sgn", 128'(bus.SIGNED_RES_RX1), 128'd1);
        tick();
        chk("t3_drain", 128'(bus.X1X2_EMPTY_SX1), 128'd1);

        // Streaming 10..16 with X2 popping every cycle
        bus.X0X1_EMPTY_SX0 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(64'(i), 64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 1'b1);
            tick();
            chk($sformatf("t4_e%0d_empty", i), 128'(bus.X1X2_EMPTY_SX1), 128'd0);
            chk($sformatf("t4_e%0d_sum", i), 128'(head_sum), 128'(10 + i));
        end
        bus.X0X1_EMPTY_SX0 = 1'b1;
        tick();
        chk("t4_drain", 128'(bus.X1X2_EMPTY_SX1), 128'd1);

        // Pop while empty: storage head (entry 15 in slot 0) stays put
        chk("t5_res_before", 128'(head_sum), 128'd15);
        tick();
        tick();
        bus.X1X2_POP_SX2 = 1'b0;
        chk("t5_empty", 128'(bus.X1X2_EMPTY_SX1), 128'd1);
        chk("t5_res_after", 128'(head_sum), 128'd15);

        // Asynchronous reset with two entries buffered
        bus.X0X1_EMPTY_SX0 = 1'b0;
        drive(64'd7, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1);
        tick();
        drive(64'd8, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1);
        tick();
        chk("t6_full_pop", 128'(bus.X0X1_POP_SX1), 128'd0);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_empty", 128'(bus.X1X2_EMPTY_SX1), 128'd1);
        chk("t6_rst_res", 128'(bus.RES_RX1), 128'd0);
        chk("t6_rst_flags", 128'({bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1}), 128'd0);
        chk("t6_rst_pop", 128'(bus.X0X1_POP_SX1), 128'd1);
        tick();
        bus.X0X1_EMPTY_SX0 = 1'b1;
        chk("t6_rst_hold", 128'(bus.X1X2_EMPTY_SX1), 128'd1);
        reset_n = 1'b1;
        tick();
        drive(64'd40, 64'd2, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        bus.X0X1_EMPTY_SX0 = 1'b0;
        tick();
        bus.X0X1_EMPTY_SX0 = 1'b1;
        chk("t6_new_sum", 128'(head_sum), 128'd42);
        bus.X1X2_POP_SX2 = 1'b1;
        tick();
        bus.X1X2_POP_SX2 = 1'b0;
        chk("t6_sole", 128'(bus.X1X2_EMPTY_SX1), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/x1_multiplier.md
Name: x1_multiplier

Overview:
- Second execute stage of the multiplier pipeline (X1).
- Pops five 64-bit carry-save partial vectors plus two result-control flags from the X0X1 FIFO.
- Reduces the five vectors to two with three chained 3:2 carry-save stages and buffers the pair in a local DEPTH-entry X1X2 FIFO.
- The final carry-propagate add and result selection happen in X2.

Parameters:
DEPTH, 2, number of X1X2 buffer entries (power of two, >=2)
W, 64, width of each partial vector

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  reset, asynchronous, active-low
RES_RX0  input  5*W  partial vectors; v0=[63:0], v1=[127:64], v2=[191:128], v3=[255:192], v4=[319:256]
SELECT_MSB_RX0  input  1  1 = upper 32 bits of product requested (MULH*), 0 = MUL
SIGNED_RES_RX0  input  1  result-sign flag from X0, carried unchanged
X0X1_EMPTY_SX0  input  1  X0X1 FIFO empty
X0X1_POP_SX1  output  1  pop request to X0X1 FIFO
X1X2_POP_SX2  input  1  X2 consumes head entry
RES_RX1  output  2*W  head entry: sum=[63:0], carry=[127:64]
SELECT_MSB_RX1  output  1  head entry flag
SIGNED_RES_RX1  output  1  head entry flag
X1X2_EMPTY_SX1  output  1  local buffer empty

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- CSA definition, per stage, all W bits:
  - S0 = A^B^C
  - S1 = ((A&B)|(A&C)|(B&C)) << 1, truncated to W bits, bit 0 = 0
- Reduction, purely combinational from RES_RX0:
  - (a,b) = csa(v0,v1,v2)
  - (c,d) = csa(a,b,v3)
  - (sum,carry) = csa(c,d,v4)
- Invariant: sum+carry == v0+v1+v2+v3+v4 mod 2^W. No sign handling in X1; the flags pass through untouched.
- Entry format: {SELECT_MSB, SIGNED_RES, carry, sum}, 2*W+2 bits.
- Buffer state: circular storage[DEPTH], wr_ptr, rd_ptr (log2 DEPTH bits each), count (log2 DEPTH + 1 bits).
  - full = (count == DEPTH), empty = (count == 0).
  - Both derive from registered count only.
- Push:
  - push = !X0X1_EMPTY_SX0 && !full.
  - X0X1_POP_SX1 = push, combinational, same cycle.
  - On push: storage[wr_ptr] <= entry; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop:
  - pop = X1X2_POP_SX2 && !empty.
  - On pop: rd_ptr increments with wrap. A pop while empty is ignored with no state change.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - When full, push is blocked even if pop is asserted the same cycle; no pass-through.
- Outputs:
  - RES_RX1/SELECT_MSB_RX1/SIGNED_RES_RX1 = storage[rd_ptr], registered data with no combinational path from RES_RX0.
  - X1X2_EMPTY_SX1 = empty.
- Latency: an entry popped from X0X1 at edge N is visible on RES_RX1 with X1X2_EMPTY_SX1=0 after edge N+1, if the buffer was empty.
- Throughput: one entry per cycle while X2 pops every cycle.
- Reset (reset_n=0, any time, including mid-transfer):
  - Immediately: count=0, pointers=0, all storage=0.
  - X1X2_EMPTY_SX1=1, RES_RX1=0, SELECT_MSB_RX1=0, SIGNED_RES_RX1=0.
  - X0X1_POP_SX1 follows X0X1_EMPTY_SX0 (buffer empty).
  - Entries in flight are discarded.
- Data on RES_RX0 while X0X1_EMPTY_SX0=1 is ignored and never written.

Test Plan:
- Reset, then X0X1_EMPTY_SX0=0, v0..v4 = 1,2,3,4,5, flags SELECT_MSB=1, SIGNED_RES=0:
  - X0X1_POP_SX1=1 that cycle.
  - Next cycle X1X2_EMPTY_SX1=0 and sum+carry = 15 mod 2^64.
  - SELECT_MSB_RX1=1, SIGNED_RES_RX1=0.
- All five vectors = 64'hFFFF_FFFF_FFFF_FFFF -> sum+carry mod 2^64 = 64'hFFFF_FFFF_FFFF_FFFB (wrap-around).
- Fill with three entries A,B,C and X1X2_POP_SX2=0:
  - A and B accepted; on C, X0X1_POP_SX1=0 while count=2.
  - Assert pop: next cycle head=B and C is pushed.
  - Order A,B,C preserved at the RES_RX1 head.
- Continuous push and pop for 7 entries, sums 10..16:
  - X2 observes them in order with no gaps after the first.
  - Pointers wrap at DEPTH=2 with no lost or duplicated entries.
- X1X2_POP_SX2=1 while empty -> count stays 0, X1X2_EMPTY_SX1=1, RES_RX1 unchanged.
- Assert reset_n=0 with 2 entries buffered:
  - Outputs clear immediately (EMPTY=1, RES_RX1=0) without a clock edge.
  - After release, the next push appears as the sole entry.
